// File: rtl/dcm_prog_responder.sv
// Slave end of the DCM PROGEN/PROGDATA/PROGDONE interface: decodes LoadD/LoadM/GO frames,
// holds active M/D and emulates the PROGDONE lock delay. Define DCM_PROG_STATS_EN for GO/err counters.
module dcm_prog_responder #(
  parameter int LOCK_CYCLES = 64,
  parameter int DEF_MULT    = 16,
  parameter int DEF_DIV     = 8,
  parameter int MIN_MULT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_en,
  input  logic        prog_data,
  output logic        prog_done,
  output logic [8:0]  mult,
  output logic [8:0]  div,
  output logic        cfg_valid,
  output logic        err
`ifdef DCM_PROG_STATS_EN
  ,
  output logic [15:0] cfg_count,
  output logic [7:0]  err_count
`endif
);

  localparam int TW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD2, S_SHIFT, S_GAP, S_LOCK} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      sr, sr_n;
  logic            is_m, is_m_n;
  logic [8:0]      pend_m, pend_m_n, pend_d, pend_d_n;
  logic            pm_vld, pm_vld_n, pd_vld, pd_vld_n;
  // a rejected GO drops prog_done for one cycle, then restores it
  logic            done_retry, done_retry_n;
  logic            prog_done_n, cfg_valid_n, err_n;
  logic [8:0]      mult_n, div_n;
  logic [8:0]      payload_val;

  assign payload_val = {1'b0, sr} + 9'd1;

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    bit_cnt_n    = bit_cnt;
    sr_n         = sr;
    is_m_n       = is_m;
    pend_m_n     = pend_m;
    pend_d_n     = pend_d;
    pm_vld_n     = pm_vld;
    pd_vld_n     = pd_vld;
    done_retry_n = 1'b0;
    prog_done_n  = prog_done;
    mult_n       = mult;
    div_n        = div;
    cfg_valid_n  = 1'b0;
    err_n        = 1'b0;
    case (state)
      S_IDLE: begin
        if (done_retry) prog_done_n = 1'b1;
        if (prog_en) begin
          prog_done_n = 1'b0;
          if (prog_data) begin
            state_n = S_CMD2;
          end else if (pm_vld && pd_vld) begin
            mult_n      = pend_m;
            div_n       = pend_d;
            cfg_valid_n = 1'b1;
            pm_vld_n    = 1'b0;
            pd_vld_n    = 1'b0;
            timer_n     = TW'(LOCK_CYCLES);
            state_n     = S_LOCK;
          end else begin
            err_n        = 1'b1;
            done_retry_n = 1'b1;
          end
        end
      end
      S_CMD2: begin
        if (prog_en) begin
          is_m_n    = prog_data;
          bit_cnt_n = 3'd0;
          state_n   = S_SHIFT;
        end else begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (prog_en) begin
          sr_n = {prog_data, sr[7:1]};
          if (bit_cnt == 3'd7) state_n = S_GAP;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end else begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_GAP: begin
        state_n = S_IDLE;
        if (prog_en) begin
          err_n = 1'b1;
        end else if (is_m) begin
          if (payload_val < 9'(MIN_MULT)) begin
            err_n = 1'b1;
          end else begin
            pend_m_n = payload_val;
            pm_vld_n = 1'b1;
          end
        end else begin
          pend_d_n = payload_val;
          pd_vld_n = 1'b1;
        end
      end
      S_LOCK: begin
        // frames during lock are flagged but do not disturb the timer
        if (prog_en) err_n = 1'b1;
        if (timer == '0) begin
          prog_done_n = 1'b1;
          state_n     = S_IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_LOCK;
      timer      <= TW'(LOCK_CYCLES);
      bit_cnt    <= 3'd0;
      sr         <= 8'd0;
      is_m       <= 1'b0;
      pend_m     <= 9'd0;
      pend_d     <= 9'd0;
      pm_vld     <= 1'b0;
      pd_vld     <= 1'b0;
      done_retry <= 1'b0;
      prog_done  <= 1'b0;
      mult       <= 9'(DEF_MULT);
      div        <= 9'(DEF_DIV);
      cfg_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_cnt    <= bit_cnt_n;
      sr         <= sr_n;
      is_m       <= is_m_n;
      pend_m     <= pend_m_n;
      pend_d     <= pend_d_n;
      pm_vld     <= pm_vld_n;
      pd_vld     <= pd_vld_n;
      done_retry <= done_retry_n;
      prog_done  <= prog_done_n;
      mult       <= mult_n;
      div        <= div_n;
      cfg_valid  <= cfg_valid_n;
      err        <= err_n;
    end
  end

`ifdef DCM_PROG_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_count <= 16'd0;
      err_count <= 8'd0;
    end else begin
      if (cfg_valid && cfg_count != '1) cfg_count <= cfg_count + 16'd1;
      if (err && err_count != '1)       err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Scoreboard bench: frame-level stimulus pushes expected cfg/err events; a negedge monitor pops and checks.
module tb_dcm_prog_responder;

  localparam int LOCK = 64;
  localparam int MINM = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_en, prog_data;
  logic       prog_done, cfg_valid, err;
  logic [8:0] mult, div;
`ifdef DCM_PROG_STATS_EN
  logic [15:0] cfg_count;
  logic [7:0]  err_count;
`endif

  dcm_prog_responder #(.LOCK_CYCLES(LOCK), .DEF_MULT(16), .DEF_DIV(8), .MIN_MULT(MINM)) dut (
    .clk(clk), .reset(reset), .prog_en(prog_en), .prog_data(prog_data),
    .prog_done(prog_done), .mult(mult), .div(div), .cfg_valid(cfg_valid), .err(err)
`ifdef DCM_PROG_STATS_EN
    , .cfg_count(cfg_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit is_cfg; int m; int d; } ev_t;
  typedef struct { string name; int act; int exp; } chk_t;

  ev_t  exp_q[$];
  chk_t chk_q[$];
  int   total = 0, bad = 0;
  bit   ending = 0, fin = 0;

  // reference model state
  int mm = 16, md = 8, pm = 0, pd = 0;
  bit pmv = 0, pdv = 0;
  int cfg_exp = 0, err_exp = 0;

  // all comparisons are performed here so the counters have a single writer
  always @(negedge clk) begin : monitor
    chk_t c;
    ev_t  e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      total++;
      if (c.act != c.exp) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
      end
    end
    if (!reset && (cfg_valid || err)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got cfg_valid=%0d err=%0d expected no event", cfg_valid, err);
      end else begin
        e = exp_q.pop_front();
        if (e.is_cfg ? !(cfg_valid && !err && mult == 9'(e.m) && div == 9'(e.d))
                     : !(err && !cfg_valid)) begin
          bad++;
          $display("FAIL event: got cfg_valid=%0d err=%0d mult=%0d div=%0d expected cfg_valid=%0d mult=%0d div=%0d",
                   cfg_valid, err, mult, div, e.is_cfg, e.m, e.d);
        end
      end
    end
    if (ending && !fin) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL missing_events: got %0d outstanding expected 0", exp_q.size());
      end
      fin = 1;
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    chk_t c;
    c.name = n; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_cfg = 0; e.m = 0; e.d = 0;
    exp_q.push_back(e);
    err_exp++;
  endtask

  task automatic push_cfg(input int m, input int d);
    ev_t e;
    e.is_cfg = 1; e.m = m; e.d = d;
    exp_q.push_back(e);
    cfg_exp++;
  endtask

  task automatic cyc(input logic en, input logic d);
    prog_en = en; prog_data = d;
    @(negedge clk);
  endtask

  // edges from the loading event (GO edge or reset release) until prog_done is seen high
  task automatic lock_wait(input string n, input int poke);
    int cnt = 0;
    while (!prog_done && cnt < 300) begin
      if (poke > 0 && cnt == poke) begin
        push_err();
        cyc(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        cyc(1'b0, 1'b0);
      end
      cnt++;
    end
    chk(n, cnt, LOCK + 1);
  endtask

  // cut<0: abort in CMD2; cut 1..7: drop en after that many bits; gapbad: en held in GAP
  task automatic load(input bit is_m, input logic [7:0] pl, input int cut, input bit gapbad, input int gaps);
    int v;
    int nb;
    cyc(1'b1, 1'b1);
    if (cut < 0) begin
      push_err();
      cyc(1'b0, 1'b0);
    end else begin
      cyc(1'b1, is_m);
      nb = (cut > 0) ? cut : 8;
      for (int i = 0; i < nb; i++) cyc(1'b1, pl[i]);
      if (cut > 0) begin
        push_err();
        cyc(1'b0, 1'b0);
      end else if (gapbad) begin
        push_err();
        cyc(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        v = int'(pl) + 1;
        if (is_m && v < MINM) push_err();
        else if (is_m) begin pm = v; pmv = 1; end
        else begin pd = v; pdv = 1; end
        cyc(1'b0, 1'b0);
      end
    end
    repeat (gaps) cyc(1'b0, 1'b0);
    chk("mult_hold", mult, mm);
    chk("div_hold", div, md);
  endtask

  task automatic go(input int poke, input bit measure);
    bit ok;
    ok = pmv && pdv;
    if (ok) begin
      push_cfg(pm, pd);
      mm = pm; md = pd; pmv = 0; pdv = 0;
    end else begin
      push_err();
    end
    cyc(1'b1, 1'b0);
    chk("go_mult", mult, mm);
    chk("go_div", div, md);
    if (ok) begin
      if (measure) lock_wait("go_lock_latency", poke);
    end else begin
      chk("bad_go_done_low", prog_done, 0);
      cyc(1'b0, 1'b0);
      chk("bad_go_done_back", prog_done, 1);
    end
  endtask

  task automatic chk_stats(input string n);
`ifdef DCM_PROG_STATS_EN
    chk({n, "_cfg_count"}, cfg_count, (cfg_exp > 65535) ? 65535 : cfg_exp);
    chk({n, "_err_count"}, err_count, (err_exp > 255) ? 255 : err_exp);
`else
    chk({n, "_outputs_mult"}, mult, mm);
`endif
  endtask

  initial begin
    int op;
    logic [7:0] pl;
    reset = 1'b1; prog_en = 1'b0; prog_data = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", prog_done, 0);
    chk("rst_mult", mult, 16);
    chk("rst_div", div, 8);
    chk("rst_err", err, 0);
    chk("rst_cfg_valid", cfg_valid, 0);
    reset = 1'b0;
    lock_wait("rst_lock_latency", 0);

    // LoadD 7, LoadM 0x31 -> M=50, D=8
    load(1'b0, 8'h07, 0, 1'b0, 3);
    load(1'b1, 8'h31, 0, 1'b0, 3);
    go(0, 1'b1);
    chk("dir_mult50", mult, 50);
    chk("dir_div8", div, 8);
    // truncated LoadM then GO: both rejected
    load(1'b1, 8'h55, 5, 1'b0, 2);
    go(0, 1'b1);
    // LoadD only then GO: rejected
    load(1'b0, 8'h03, 0, 1'b0, 2);
    go(0, 1'b1);
    // M=1 rejected, then M=256 with the still-pending D
    load(1'b1, 8'h00, 0, 1'b0, 1);
    load(1'b1, 8'hFF, 0, 1'b0, 1);
    go(30, 1'b1);
    chk("dir_mult256", mult, 256);
    chk("dir_div4", div, 4);
    chk_stats("mid");

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      pl = 8'($urandom_range(0, 255));
      case (op)
        0, 1, 2: load(1'b0, pl, 0, 1'b0, $urandom_range(0, 3));
        3, 4:    load(1'b1, pl, 0, 1'b0, $urandom_range(0, 3));
        5:       load(1'b1, 8'($urandom_range(0, 2)), 0, 1'b0, $urandom_range(0, 3));
        6:       load(1'($urandom_range(0, 1)), pl, ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(1, 7),
                      1'b0, $urandom_range(0, 3));
        7:       load(1'($urandom_range(0, 1)), pl, 0, 1'b1, $urandom_range(0, 3));
        default: go(($urandom_range(0, 1) == 1) ? $urandom_range(5, 50) : 0, 1'b1);
      endcase
    end

    // reset 20 cycles into LOCK
    load(1'b0, 8'h0B, 0, 1'b0, 1);
    load(1'b1, 8'h09, 0, 1'b0, 1);
    go(0, 1'b0);
    repeat (20) cyc(1'b0, 1'b0);
    chk_stats("pre_rst");
    reset = 1'b1;
    #1;
    mm = 16; md = 8; pmv = 0; pdv = 0; cfg_exp = 0; err_exp = 0;
    chk("mid_rst_mult", mult, 16);
    chk("mid_rst_div", div, 8);
    chk("mid_rst_done", prog_done, 0);
    @(negedge clk);
    reset = 1'b0;
    lock_wait("rst2_lock_latency", 0);
    chk_stats("post_rst");
    // pend flags lost: a GO now must be rejected
    go(0, 1'b1);

    repeat (5) cyc(1'b0, 1'b0);
    ending = 1;
    for (int i = 0; i < 10 && !fin; i++) @(negedge clk);
    if (!fin) begin
      $display("FAIL monitor_finish: got not finished expected finished");
      $fatal(1, "monitor did not complete");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
